// File: rtl/falcon_mem_pkg.sv
// Shared definitions for the DDR manager front end: arbiter states,
// default bus widths and manager timing constants used by benches.
package falcon_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 32;

  // Manager-side timing slice, exported for benches modelling the manager.
  localparam int LATCH_TIME = 4;
  localparam int NO_RETURN  = 2;

endpackage

// File: rtl/mem_request_arbiter_rr_priority_pick.sv
// Rotating priority encoder: first asserted request scanning upward
// from rr_ptr, wrapping modulo N.
module rr_priority_pick #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             valid,
  output logic [PTR_W-1:0] index
);

  logic [31:0] ptr_ext;

  always_comb begin
    ptr_ext = 32'(rr_ptr);
    valid   = |req;
    index   = '0;
    // Two descending passes, later writes win: wrapped entries below rr_ptr
    // first, then entries at/above rr_ptr override them.
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1] && ((i - 1) < ptr_ext)) index = PTR_W'(i - 1);
    end
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1] && ((i - 1) >= ptr_ext)) index = PTR_W'(i - 1);
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter multiplexing single-word requesters onto the DDR
// manager's one-word port; holds the request until the manager drops pause.
module mem_request_arbiter
  import falcon_mem_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int SETTLE_CYCLES = 1,
  parameter int TIMEOUT       = 1023
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wren,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_wren,
  output logic [DATA_W-1:0]         mem_data_write,
  output logic [ADDR_W-1:0]         mem_address,
  input  logic [DATA_W-1:0]         mem_data_read,
  input  logic                      mem_pause,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int          PTR_W   = $clog2(NUM_REQ);
  localparam logic [9:0]  TO_MAX  = 10'(TIMEOUT);
  localparam logic [9:0]  TO_LAST = 10'(TIMEOUT - 1);
  localparam bit          TO_EN   = (TIMEOUT != 0);

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, gnt, pick_idx;
  logic             pick_valid;
  logic [3:0]       settle_cnt;
  logic [9:0]       wait_cnt;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  rr_priority_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (mem_ready && pick_valid) state_nxt = ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt <= 4'd1) state_nxt = ST_WAIT;
      ST_WAIT:   if (!mem_pause) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state == ST_DONE) ack[gnt] = 1'b1;
    busy        = (state != ST_IDLE);
    err_timeout = TO_EN && (state == ST_WAIT) && mem_pause && (wait_cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr         <= '0;
      gnt            <= '0;
      settle_cnt     <= '0;
      wait_cnt       <= '0;
      rdata          <= '0;
      mem_wren       <= 1'b0;
      mem_data_write <= '0;
      mem_address    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mem_ready && pick_valid) begin
            gnt            <= pick_idx;
            mem_wren       <= req_wren[pick_idx];
            mem_address    <= addr_arr[pick_idx];
            mem_data_write <= wdata_arr[pick_idx];
          end
        end
        ST_ISSUE: begin
          settle_cnt <= 4'(SETTLE_CYCLES);
          wait_cnt   <= '0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt - 1'b1;
        ST_WAIT: begin
          // Counter saturates at TIMEOUT so the error pulses once per stall.
          if (!mem_pause)                      rdata    <= mem_data_read;
          else if (TO_EN && wait_cnt != TO_MAX) wait_cnt <= wait_cnt + 1'b1;
        end
        ST_DONE: begin
          rr_ptr   <= (gnt == PTR_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
          mem_wren <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboard bench for mem_request_arbiter with a simple manager model.
module tb_mem_request_arbiter;

  localparam int NR = 3;
  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NR-1:0] req;
  logic [NR-1:0] req_wren;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0] ack;
  logic [DW-1:0] rdata;
  logic          mem_wren;
  logic [DW-1:0] mem_data_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_read;
  logic          mem_pause;
  logic          mem_ready;
  logic          busy;
  logic          err_timeout;

  logic [AW-1:0] a  [NR];
  logic [DW-1:0] d  [NR];
  int            want [NR];
  int            got  [NR];
  logic          use_fixed;
  logic [DW-1:0] fixed_word;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  typedef struct {
    logic [NR-1:0] ack;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign req_addr  = {a[2], a[1], a[0]};
  assign req_wdata = {d[2], d[1], d[0]};

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] addr);
    return {14'h0, addr} ^ 32'hC0DE0000;
  endfunction

  // Manager model: echoes write data, otherwise returns an address-derived word.
  assign mem_data_read = mem_wren ? mem_data_write :
                         (use_fixed ? fixed_word : rd_fn(mem_address));

  mem_request_arbiter #(
    .NUM_REQ       (NR),
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .SETTLE_CYCLES (1),
    .TIMEOUT       (1023)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_wren       (req_wren),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .ack            (ack),
    .rdata          (rdata),
    .mem_wren       (mem_wren),
    .mem_data_write (mem_data_write),
    .mem_address    (mem_address),
    .mem_data_read  (mem_data_read),
    .mem_pause      (mem_pause),
    .mem_ready      (mem_ready),
    .busy           (busy),
    .err_timeout    (err_timeout)
  );

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Requester agents: request level held while transactions are outstanding.
  initial begin
    req = '0;
    for (int i = 0; i < NR; i++) got[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (reset_n && ack[i]) got[i] = got[i] + 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) req[i] = (want[i] > got[i]);
    end
  end

  // Monitor: every ack is matched against the next expected transaction.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_n && ack != '0) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_ack: ack=%b rdata=%h with nothing expected", ack, rdata);
      end else begin
        e = exp_q.pop_front();
        if (ack !== e.ack || rdata !== e.rdata) begin
          errors = errors + 1;
          $display("FAIL ack_data: got ack=%b rdata=%h, expected ack=%b rdata=%h",
                   ack, rdata, e.ack, e.rdata);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [DW-1:0] rd);
    exp_t e;
    e.ack = '0;
    e.ack[idx] = 1'b1;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_drain: %0d transactions still pending after %0d cycles",
               tag, exp_q.size(), max_cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    int c0, busy_cnt, ack_at, err_cnt, err_at;
    int g0 [NR];
    logic bad;

    reset_n = 1'b0;
    mem_ready = 1'b1;
    mem_pause = 1'b0;
    use_fixed = 1'b0;
    fixed_word = '0;
    req_wren = '0;
    a[0] = 18'h00010; a[1] = 18'h00020; a[2] = 18'h00030;
    d[0] = 32'h0;     d[1] = 32'h0;     d[2] = 32'h0;
    for (int i = 0; i < NR; i++) want[i] = 1;

    // 1: reset with all requesting
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_wren", 64'(mem_wren), 64'(0));
    check("rst_addr", 64'(mem_address), 64'(0));
    check("rst_wdata", 64'(mem_data_write), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err_timeout), 64'(0));
    push(0, rd_fn(18'h00010));
    push(1, rd_fn(18'h00020));
    push(2, rd_fn(18'h00030));
    reset_n = 1'b1;
    drain(100, "reset_release");

    // 2: single read, latency and data
    a[1] = 18'h000A5;
    use_fixed = 1'b1;
    fixed_word = 32'hDEADBEEF;
    push(1, 32'hDEADBEEF);
    want[1] = want[1] + 1;
    @(posedge clk);
    #2;
    c0 = cyc;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_wren) bad = 1'b1;
      if (ack != '0) break;
    end
    check("read_latency", 64'(cyc - c0), 64'(4));
    check("read_wren_low", 64'(bad), 64'(0));
    drain(50, "read");
    use_fixed = 1'b0;

    // 3: write with pause held for 7 busy cycles
    a[2] = 18'h3FFFF;
    d[2] = 32'h12345678;
    req_wren[2] = 1'b1;
    mem_pause = 1'b1;
    push(2, 32'h12345678);
    want[2] = want[2] + 1;
    busy_cnt = 0;
    ack_at = -1;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) begin
        if (!mem_wren || mem_address != 18'h3FFFF || mem_data_write != 32'h12345678) bad = 1'b1;
        busy_cnt++;
      end
      if (ack != '0) begin
        ack_at = busy_cnt;
        break;
      end
      if (busy_cnt == 7) mem_pause = 1'b0;
    end
    check("write_stable", 64'(bad), 64'(0));
    check("write_ack_cycle", 64'(ack_at), 64'(8));
    drain(50, "write");
    @(negedge clk);
    check("write_wren_idle", 64'(mem_wren), 64'(0));
    req_wren[2] = 1'b0;

    // 4: fairness with all three requesting for 9 transactions
    a[0] = 18'h01111; a[1] = 18'h02222; a[2] = 18'h03333;
    for (int i = 0; i < NR; i++) g0[i] = got[i];
    for (int r = 0; r < 3; r++) begin
      push(0, rd_fn(18'h01111));
      push(1, rd_fn(18'h02222));
      push(2, rd_fn(18'h03333));
    end
    for (int i = 0; i < NR; i++) want[i] = want[i] + 3;
    drain(300, "fairness");
    for (int i = 0; i < NR; i++) check($sformatf("fair_count%0d", i), 64'(got[i] - g0[i]), 64'(3));

    // 5: mem_ready gating
    mem_ready = 1'b0;
    a[0] = 18'h00777;
    push(0, rd_fn(18'h00777));
    want[0] = want[0] + 1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy || ack != '0 || mem_wren) bad = 1'b1;
    end
    check("gate_idle", 64'(bad), 64'(0));
    mem_ready = 1'b1;
    @(negedge clk);
    check("gate_issue_next", 64'(busy), 64'(1));
    drain(50, "gate");

    // 6: stuck pause -> timeout pulse, then reset mid-WAIT
    a[1] = 18'h1ABCD;
    d[1] = 32'hCAFEF00D;
    req_wren[1] = 1'b1;
    mem_pause = 1'b1;
    want[1] = want[1] + 1;
    busy_cnt = 0;
    err_cnt = 0;
    err_at = -1;
    bad = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (err_timeout) begin
        err_cnt++;
        err_at = busy_cnt;
      end
      if (ack != '0) bad = 1'b1;
      if (busy_cnt == 1060) break;
    end
    check("timeout_pulses", 64'(err_cnt), 64'(1));
    check("timeout_cycle", 64'(err_at), 64'(1025));
    check("timeout_no_ack", 64'(bad), 64'(0));
    check("timeout_wren_held", 64'(mem_wren), 64'(1));
    want[1] = got[1];
    reset_n = 1'b0;
    #1;
    check("abort_wren", 64'(mem_wren), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ack", 64'(ack), 64'(0));
    check("abort_rdata", 64'(rdata), 64'(0));
    mem_pause = 1'b0;
    req_wren[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy || ack != '0) bad = 1'b1;
    end
    check("abort_quiet", 64'(bad), 64'(0));
    check("abort_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
